// File: rtl/pdm_mic_emulator.sv
// PDM MEMS microphone emulator.
// Takes signed PCM samples over valid/ready, holds each for hold_num+1 PDM
// bits, and turns the held value into a 1-bit stream with a first-order
// carry-out sigma-delta. Bits launch on the selected edge of the receiver's
// microphone clock, which is synchronised into the system clock domain.
module pdm_mic_emulator #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              mic_clk,
  input  logic              channel,
  input  logic [7:0]        hold_num,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              data_out,
  output logic              data_oe,
  output logic              underrun,
  output logic [15:0]       underrun_cnt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   live_q;
  logic                   mic_prev;
  logic                   mic_s;
  logic                   edge_seen;
  logic                   launch_edge;
  logic                   release_edge;

  logic [DATA_W-1:0]      acc_q;
  logic [DATA_W-1:0]      cur_q;
  logic [DATA_W-1:0]      pend_q;
  logic                   pend_full;
  logic [7:0]             bit_cnt;

  logic [DATA_W-1:0]      u;
  logic [DATA_W:0]        sum;
  logic                   boundary;
  logic                   accept;

  assign mic_s = sync_q[SYNC_STAGES-1];

  // live_q fills with ones after reset; edges only count once the synchroniser
  // and the previous-value flop both hold genuinely sampled mic_clk values,
  // so a mic_clk already high at reset release is not mistaken for an edge.
  assign edge_seen    = live_q[SYNC_STAGES] && (mic_s != mic_prev);
  assign launch_edge  = edge_seen && (channel ? mic_s : ~mic_s);
  assign release_edge = edge_seen && (channel ? ~mic_s : mic_s);

  // Offset-binary view of the held sample feeds the carry-out accumulator.
  assign u        = {~cur_q[DATA_W-1], cur_q[DATA_W-2:0]};
  assign sum      = {1'b0, acc_q} + {1'b0, u};
  assign boundary = (bit_cnt >= hold_num);

  assign sample_ready = ~pend_full;
  assign accept       = sample_valid && sample_ready;

  // Synchronise mic_clk and keep its previous value for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      live_q   <= '0;
      mic_prev <= 1'b0;
    end else begin
      sync_q[0] <= mic_clk;
      live_q[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      for (int i = 1; i <= SYNC_STAGES; i++) begin
        live_q[i] <= live_q[i-1];
      end
      mic_prev <= mic_s;
    end
  end

  // Modulator, hold counter, sample buffers, data line and underrun tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out     <= 1'b0;
      data_oe      <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
      acc_q        <= '0;
      cur_q        <= '0;
      pend_q       <= '0;
      pend_full    <= 1'b0;
      bit_cnt      <= '0;
    end else begin
      underrun <= 1'b0;
      if (!enable) begin
        data_out <= 1'b0;
        data_oe  <= 1'b0;
      end else if (launch_edge) begin
        data_out <= sum[DATA_W];
        data_oe  <= 1'b1;
        acc_q    <= sum[DATA_W-1:0];
        if (boundary) begin
          bit_cnt <= '0;
          if (pend_full) begin
            cur_q     <= pend_q;
            pend_full <= 1'b0;
          end else begin
            underrun <= 1'b1;
            if (underrun_cnt != 16'hFFFF) begin
              underrun_cnt <= underrun_cnt + 16'd1;
            end
          end
        end else begin
          bit_cnt <= bit_cnt + 8'd1;
        end
      end else if (release_edge) begin
        data_oe <= 1'b0;
      end
      if (accept) begin
        pend_q    <= sample_in;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pdm_mic_emulator.sv
// Self-checking bench for pdm_mic_emulator: a table of single-sample windows
// with hand-computed ones counts, plus directed sequences for latency,
// channel selection, reset, pause, back-to-back handshake and saturation.
module tb_pdm_mic_emulator;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        mic_clk;
  logic        channel;
  logic [7:0]  hold_num;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        data_out;
  logic        data_oe;
  logic        underrun;
  logic [15:0] underrun_cnt;

  int checks;
  int errors;
  int pulse_cnt;

  typedef struct {
    logic [15:0] sample;
    int          exp_ones;
  } vec_t;

  vec_t vecs[8];

  pdm_mic_emulator #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .mic_clk(mic_clk),
    .channel(channel),
    .hold_num(hold_num),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .data_out(data_out),
    .data_oe(data_oe),
    .underrun(underrun),
    .underrun_cnt(underrun_cnt)
  );

  // 50 MHz system clock.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Count clk cycles in which the underrun pulse is high.
  initial pulse_cnt = 0;
  always @(negedge clk) begin
    if (underrun === 1'b1) pulse_cnt++;
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n        = 1'b0;
    enable       = 1'b1;
    mic_clk      = 1'b0;
    channel      = 1'b1;
    sample_valid = 1'b0;
    sample_in    = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [15:0] s, input string name);
    logic ok;
    ok = 1'b0;
    sample_in    = s;
    sample_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (sample_ready === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    sample_valid = 1'b0;
    check_output({"accept_", name}, {63'd0, ok}, 64'd1);
  endtask

  // One mic_clk period: launch phase then release phase, 4 clks each.
  task automatic mic_cycle(input logic lvl, input logic exp_on, output logic b, output int bad);
    bad = 0;
    @(negedge clk);
    mic_clk = lvl;
    repeat (4) @(negedge clk);
    b = data_out;
    if (data_oe !== exp_on) bad++;
    mic_clk = ~lvl;
    repeat (4) @(negedge clk);
    if (data_oe !== 1'b0) bad++;
  endtask

  task automatic run_bits(input int n, input logic lvl, input logic exp_on,
                          output logic [63:0] bits, output int ones, output int bad);
    logic b;
    int   cb;
    bits = '0;
    ones = 0;
    bad  = 0;
    for (int i = 0; i < n; i++) begin
      mic_cycle(lvl, exp_on, b, cb);
      bits[i] = b;
      if (b === 1'b1) ones++;
      bad += cb;
    end
  endtask

  initial begin
    logic [63:0] bits;
    logic [63:0] bits2;
    int          ones;
    int          bad;
    int          bad2;
    int          base;
    int          accepts;
    logic [15:0] seq[4];

    checks = 0;
    errors = 0;

    vecs[0] = '{16'h7FFF, 7};
    vecs[1] = '{16'h8000, 0};
    vecs[2] = '{16'h4000, 6};
    vecs[3] = '{16'h0000, 4};
    vecs[4] = '{16'hC000, 2};
    vecs[5] = '{16'h2000, 5};
    vecs[6] = '{16'hE000, 3};
    vecs[7] = '{16'h0001, 4};

    // Reset values.
    hold_num = 8'd3;
    apply_reset();
    check_output("reset_outputs", {59'd0, data_out, data_oe, sample_ready, underrun, 1'b0},
                 {59'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    check_output("reset_cnt", {48'd0, underrun_cnt}, 64'd0);

    // Idle stream on rising edge: latency, alternating bits, underrun every 4 bits.
    base = pulse_cnt;
    @(negedge clk);
    mic_clk = 1'b1;
    repeat (2) @(negedge clk);
    check_output("latency_early", {63'd0, data_oe}, 64'd0);
    @(negedge clk);
    check_output("latency_on", {62'd0, data_oe, data_out}, 64'd2);
    mic_clk = 1'b0;
    repeat (4) @(negedge clk);
    run_bits(7, 1'b1, 1'b1, bits, ones, bad);
    check_output("idle_bits", bits, 64'h55);
    check_output("idle_oe", bad, 0);
    check_output("idle_underrun_cnt", {48'd0, underrun_cnt}, 64'd2);
    check_output("idle_underrun_pulses", pulse_cnt - base, 2);

    // Falling-edge launch gives the same sequence with data_oe low in the high phase.
    apply_reset();
    channel = 1'b0;
    @(negedge clk);
    mic_clk = 1'b1;
    repeat (4) @(negedge clk);
    check_output("ch0_release_oe", {63'd0, data_oe}, 64'd0);
    run_bits(8, 1'b0, 1'b1, bits, ones, bad);
    check_output("ch0_bits", bits, 64'hAA);
    check_output("ch0_oe", bad, 0);
    check_output("ch0_underrun_cnt", {48'd0, underrun_cnt}, 64'd2);

    // Table: one sample held for 8 bits after an idle window of 8 bits.
    for (int v = 0; v < 8; v++) begin
      apply_reset();
      hold_num = 8'd7;
      apply_stimulus(vecs[v].sample, $sformatf("vec%0d", v));
      run_bits(8, 1'b1, 1'b1, bits, ones, bad);
      run_bits(8, 1'b1, 1'b1, bits2, ones, bad2);
      check_output($sformatf("vec%0d_ones", v), ones, vecs[v].exp_ones);
      check_output($sformatf("vec%0d_underrun_cnt", v), {48'd0, underrun_cnt}, 64'd1);
    end

    // Back-to-back samples with sample_valid held high.
    apply_reset();
    hold_num = 8'd1;
    seq[0] = 16'h7FFF;
    seq[1] = 16'h8000;
    seq[2] = 16'h7FFF;
    seq[3] = 16'h8000;
    accepts = 0;
    fork
      begin
        sample_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
          sample_in = seq[k];
          for (int n = 0; n < 2000; n++) begin
            if (sample_ready === 1'b1) break;
            @(negedge clk);
          end
          @(negedge clk);
          accepts++;
        end
        sample_valid = 1'b0;
      end
    join_none
    run_bits(9, 1'b1, 1'b1, bits, ones, bad);
    check_output("stream_no_underrun", {48'd0, underrun_cnt}, 64'd0);
    run_bits(1, 1'b1, 1'b1, bits2, ones, bad2);
    bits[9] = bits2[0];
    check_output("stream_bits", bits, 64'h0CA);
    check_output("stream_accepts", accepts, 4);
    check_output("stream_final_underrun", {48'd0, underrun_cnt}, 64'd1);

    // Asynchronous reset mid-hold with a sample being offered.
    apply_reset();
    hold_num = 8'd0;
    run_bits(1, 1'b1, 1'b1, bits, ones, bad);
    @(negedge clk);
    mic_clk = 1'b1;
    repeat (4) @(negedge clk);
    check_output("pre_reset_line", {62'd0, data_out, data_oe}, 64'd3);
    sample_in    = 16'h1234;
    sample_valid = 1'b1;
    #5 rst_n = 1'b0;
    #1;
    check_output("async_reset_outputs", {61'd0, data_out, data_oe, sample_ready}, 64'd1);
    check_output("async_reset_cnt", {48'd0, underrun_cnt}, 64'd0);
    sample_valid = 1'b0;
    mic_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    run_bits(4, 1'b1, 1'b1, bits, ones, bad);
    check_output("post_reset_bits", bits, 64'hA);
    check_output("post_reset_cnt", {48'd0, underrun_cnt}, 64'd4);

    // Pause: enable low for 10 periods; the sequence resumes where it stopped.
    apply_reset();
    hold_num = 8'd7;
    run_bits(3, 1'b1, 1'b1, bits, ones, bad);
    enable = 1'b0;
    run_bits(10, 1'b1, 1'b0, bits2, ones, bad2);
    check_output("pause_line_idle", {bits2[9:0], 32'd0} | bad2, 64'd0);
    enable = 1'b1;
    run_bits(3, 1'b1, 1'b1, bits2, ones, bad2);
    bits[5:3] = bits2[2:0];
    check_output("pause_resume_bits", bits, 64'h2A);
    check_output("pause_oe", bad + bad2, 0);

    // Saturation of the underrun counter, preloaded near full scale.
    apply_reset();
    hold_num = 8'd0;
    @(negedge clk);
    force dut.underrun_cnt = 16'hFFFC;
    @(negedge clk);
    release dut.underrun_cnt;
    run_bits(2, 1'b1, 1'b1, bits, ones, bad);
    check_output("sat_near", {48'd0, underrun_cnt}, 64'hFFFE);
    run_bits(4, 1'b1, 1'b1, bits, ones, bad);
    check_output("sat_full", {48'd0, underrun_cnt}, 64'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdm_mic_emulator.md
Name: pdm_mic_emulator

Overview:
Emulates the PDM MEMS microphone at the far end of the microphone interface, so the CIC decimation path can be exercised on hardware with known stimulus. It accepts signed PCM samples over a valid/ready handshake and holds each sample for a programmable number of PDM bits. Each held sample is converted to a 1-bit PDM stream by a first-order sigma-delta (carry-out accumulator). Bits are launched on the selected edge of the microphone clock produced by the receiver.

Parameters:
DATA_W, 16, PCM sample width; also the accumulator width.
SYNC_STAGES, 2, flip-flop stages synchronising mic_clk into clk.

Ports:
clk  in  1  system clock, 50 MHz.
rst_n  in  1  asynchronous active-low reset.
enable  in  1  1 = run; 0 = freeze the modulator and release the data line.
mic_clk  in  1  microphone clock from the receiver (nominally 1 MHz).
channel  in  1  1 = launch on mic_clk rising edge; 0 = launch on falling edge.
hold_num  in  8  each sample is held for hold_num+1 PDM bits.
sample_in  in  DATA_W  signed two's-complement PCM sample.
sample_valid  in  1  sample_in is valid.
sample_ready  out  1  the pending buffer can accept a sample.
data_out  out  1  PDM bit to the receiver.
data_oe  out  1  data_out is being driven (for an external tri-state).
underrun  out  1  one-clk pulse: a sample boundary was reached with no pending sample.
underrun_cnt  out  16  saturating count of underrun events.

Behaviour:
- Reset (asynchronous, rst_n=0), all values below:
  - data_out=0, data_oe=0, sample_ready=1, underrun=0, underrun_cnt=0.
  - Accumulator=0, bit counter=0, current sample=0, pending buffer empty.
  - Synchroniser flops=0.
- Reset deassertion mid-stream: no edge is detected until the synchronised mic_clk makes a real transition.
- mic_clk passes through SYNC_STAGES flops, then a registered previous value for edge detection.
  - launch_edge: rising edge if channel=1, falling edge if channel=0.
  - release_edge: the opposite edge.
- Edge-to-pin latency: data_out and data_oe update SYNC_STAGES+1 clk cycles after the mic_clk transition (3 cycles with defaults).
- Data line control:
  - On launch_edge with enable=1: data_out = new bit, data_oe=1.
  - On release_edge: data_oe=0; data_out holds its value.
  - enable=0: data_oe=0, data_out=0, no bits generated. Accumulator, bit counter and buffers are held; the pending buffer still accepts one sample.
- Modulator (evaluated on each launch_edge with enable=1):
  - u = current sample with its MSB inverted (offset binary, 0..2^DATA_W-1).
  - {carry, sum} = acc + u, computed in DATA_W+1 bits.
  - New bit = carry; acc <= sum (the low DATA_W bits).
  - Ones density is u/2^DATA_W. sample 0 gives alternating bits 0,1,0,1...; the most negative value gives all zeros.
- Sample boundary (evaluated on the same launch_edge, after the bit is computed):
  - If bit counter >= hold_num: the bit counter goes to 0 and a boundary occurs. Using >= means a hold_num reduced mid-hold wraps immediately.
  - Otherwise the bit counter increments.
  - The emitted bit always uses the old current sample; a newly loaded sample takes effect from the next launch.
  - At a boundary with the pending buffer full: current <= pending, pending is emptied, and sample_ready rises the next clk.
  - At a boundary with the pending buffer empty: current is kept (repeated), underrun is pulsed for 1 clk, and underrun_cnt increments, saturating at 0xFFFF.
- Handshake:
  - A sample is accepted when sample_valid && sample_ready; it is written to pending and sample_ready drops the next clk.
  - sample_valid may stay high while sample_ready is low; the sample is held off, not lost.
  - Accept and boundary in the same clk with pending empty: the underrun fires (the boundary sees empty) and the accepted sample lands in pending.
  - Accept and boundary in the same clk with pending full cannot occur, because sample_ready=0 while pending is full.
- A change of channel mid-stream takes effect at the next detected edge; the bit counter and accumulator are not disturbed.

Test Plan:
1. Reset, enable=1, channel=1, hold_num=63, no samples, 64+ mic_clk periods.
   -> Bits are 0,1,0,1... (current=0). underrun pulses once every 64 bits. data_oe is high only during the mic_clk high phase, 3 clks delayed.
2. Feed 0x7FFF, then 0x8000, then 0x4000 (hold_num=63, receiver dec_num=63).
   -> The 64-bit windows contain 63 or 64 ones, then 0 ones, then 48 ones. sample_ready drops after each accept and rises one clk after each load.
3. sample_valid held high continuously with a sample sequence.
   -> Each sample is accepted exactly once, in order, and underrun_cnt stays 0.
4. channel=0.
   -> Bits launch 3 clks after the mic_clk falling edge; data_oe is low during the high phase; the bit sequence is identical to case 1.
5. Force 70000 underruns (hold_num=0, no samples).
   -> underrun_cnt saturates at 0xFFFF.
6. Assert rst_n=0 mid-hold and mid-accept.
   -> All outputs return to reset values immediately. After release, the stream restarts as in case 1. Separately, enable=0 for 10 periods, then back to 1: no bits are lost and the sequence resumes where it left off.
